// File: rtl/line_buffer_window_if.sv
// ---------------------------------------------------------------------------
// line_buffer_window_if
//   Bundles the pixel-stream and window-output signals of line_buffer_window.
//
//   Handshake: there is no back-pressure. in_valid qualifies in_pixel, and the
//   pixel is consumed on the rising edge where in_valid=1 and the block is in
//   RUN without a valid start in the same cycle. out_en qualifies out for
//   exactly one cycle. start, done and err are single-cycle pulses.
//
//   master : frame source and window sink (drives start/dims/pixels)
//   slave  : line_buffer_window
// ---------------------------------------------------------------------------
interface line_buffer_window_if #(
  parameter int cell_bit = 8,
  parameter int N_cell   = 9,
  parameter int DIM_BITS = 6
);
  logic                       start;
  logic [DIM_BITS-1:0]        img_width;
  logic [DIM_BITS-1:0]        img_height;
  logic [cell_bit-1:0]        in_pixel;
  logic                       in_valid;
  logic [cell_bit*N_cell-1:0] out;
  logic                       out_en;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, img_width, img_height, in_pixel, in_valid,
    input  out, out_en, busy, done, err
  );

  modport slave (
    input  start, img_width, img_height, in_pixel, in_valid,
    output out, out_en, busy, done, err
  );
endinterface

// File: rtl/line_buffer_window.sv
// ---------------------------------------------------------------------------
// line_buffer_window
//   Converts a raster-order pixel stream into 3x3 windows (stride 1, no
//   padding) for the convolution array. Two line buffers hold the previous
//   two rows; a 3x3 register window slides left by one column per accepted
//   pixel. Every fully populated window (row>=2, col>=2) is registered onto
//   out with a one-cycle out_en.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high
//   bus          : line_buffer_window_if.slave
//                  start/img_width/img_height : begin a frame, dims sampled
//                  in_pixel/in_valid          : pixel stream
//                  out/out_en                 : window word, cell k=3*r+c
//                  busy/done/err              : frame status pulses/levels
//   o_dbg_state  : current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------
module line_buffer_window #(
  parameter int cell_bit  = 8,
  parameter int N_cell    = 9,
  parameter int MAX_WIDTH = 32,
  parameter int DIM_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  line_buffer_window_if.slave   bus,
  output logic [1:0]            o_dbg_state
);

  localparam int WIN_W     = cell_bit * N_cell;
  localparam int COL_IDX_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [DIM_BITS-1:0]   r_width;
  logic [DIM_BITS-1:0]   r_height;
  logic [DIM_BITS-1:0]   r_row;
  logic [DIM_BITS-1:0]   r_col;
  logic [WIN_W-1:0]      r_win;
  logic [WIN_W-1:0]      r_out;
  logic                  r_out_en;
  logic                  r_err;

  // Line buffers: r_lb_top holds row r-2, r_lb_mid holds row r-1 at each column.
  logic [cell_bit-1:0]   r_lb_top [MAX_WIDTH];
  logic [cell_bit-1:0]   r_lb_mid [MAX_WIDTH];

  logic                  w_dims_ok;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_accept;
  logic                  w_last_col;
  logic                  w_last_pix;
  logic                  w_win_full;
  logic [COL_IDX_W-1:0]  w_col_idx;
  logic [WIN_W-1:0]      w_win_next;

  // Height upper bound is implied by the port width.
  assign w_dims_ok   = (bus.img_width  >= DIM_BITS'(3)) &&
                       (bus.img_width  <= DIM_BITS'(MAX_WIDTH)) &&
                       (bus.img_height >= DIM_BITS'(3));
  assign w_start_ok  = bus.start &&  w_dims_ok;
  assign w_start_bad = bus.start && !w_dims_ok;

  // A valid start wins over a pixel in the same cycle; a rejected start
  // leaves the running frame untouched, so its pixel is still taken.
  assign w_accept    = bus.in_valid && (r_state == S_RUN) && !w_start_ok;

  assign w_last_col  = (r_col == r_width  - DIM_BITS'(1));
  assign w_last_pix  = w_last_col && (r_row == r_height - DIM_BITS'(1));
  assign w_win_full  = (r_row >= DIM_BITS'(2)) && (r_col >= DIM_BITS'(2));
  assign w_col_idx   = r_col[COL_IDX_W-1:0];

  // Window after this accept: shift columns left, new right column comes
  // from the two line buffers plus the incoming pixel.
  always_comb begin
    w_win_next = r_win;
    for (int rr = 0; rr < 3; rr++) begin
      w_win_next[cell_bit*(3*rr)   +: cell_bit] = r_win[cell_bit*(3*rr+1) +: cell_bit];
      w_win_next[cell_bit*(3*rr+1) +: cell_bit] = r_win[cell_bit*(3*rr+2) +: cell_bit];
    end
    w_win_next[cell_bit*2 +: cell_bit] = r_lb_top[w_col_idx];
    w_win_next[cell_bit*5 +: cell_bit] = r_lb_mid[w_col_idx];
    w_win_next[cell_bit*8 +: cell_bit] = bus.in_pixel;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_start_ok) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_RUN:   if (w_accept && w_last_pix) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = (r_state == S_DONE);
  end

  // Datapath: dims, counters, sliding window, output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_width  <= '0;
      r_height <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_win    <= '0;
      r_out    <= '0;
      r_out_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_out_en <= 1'b0;
      r_err    <= w_start_bad;
      if (w_start_ok) begin
        r_width  <= bus.img_width;
        r_height <= bus.img_height;
        r_row    <= '0;
        r_col    <= '0;
      end else if (w_accept) begin
        r_win <= w_win_next;
        if (w_win_full) begin
          r_out    <= w_win_next;
          r_out_en <= 1'b1;
        end
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + DIM_BITS'(1);
        end else begin
          r_col <= r_col + DIM_BITS'(1);
        end
      end
    end
  end

  // Line buffer contents are never emitted before being rewritten, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb_top[w_col_idx] <= r_lb_mid[w_col_idx];
      r_lb_mid[w_col_idx] <= bus.in_pixel;
    end
  end

  assign bus.out     = r_out;
  assign bus.out_en  = r_out_en;
  assign bus.err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_line_buffer_window.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_window
//   Drives frames into line_buffer_window and checks every cycle against a
//   frame-level reference: accepted pixels are stored in an image array and
//   each expected window is sliced straight out of that image.
// ---------------------------------------------------------------------------
module tb_line_buffer_window;

  localparam int CB   = 8;
  localparam int NC   = 9;
  localparam int MAXW = 32;
  localparam int DB   = 6;
  localparam int WW   = CB * NC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  line_buffer_window_if #(.cell_bit(CB), .N_cell(NC), .DIM_BITS(DB)) bus ();

  line_buffer_window #(
    .cell_bit(CB), .N_cell(NC), .MAX_WIDTH(MAXW), .DIM_BITS(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [WW-1:0] exp_q [$];   // windows the model says are due
  logic [WW-1:0] got_q [$];   // windows seen on out_en in the current test
  logic [WW-1:0] basic_q [$]; // windows from the steady W=4,H=4 frame

  logic [7:0] img [0:63][0:31];
  bit         m_run;
  int         m_w, m_h, m_r, m_c;
  logic [WW-1:0] m_out;

  function automatic logic [WW-1:0] window_at(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[CB*(3*i+j) +: CB] = img[r-2+i][c-2+j];
    return w;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_r   = 0;
    m_c   = 0;
    m_out = '0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs change at the falling edge; outputs are sampled at the next
  // falling edge, half a cycle after the rising edge that produced them.
  task automatic cycle(input bit st, input int w, input int h,
                       input logic [7:0] px, input bit vld);
    bit e_en, e_done, e_err, start_ok;
    bus.start      = st;
    bus.img_width  = DB'(w);
    bus.img_height = DB'(h);
    bus.in_pixel   = px;
    bus.in_valid   = vld;
    @(posedge clk);
    e_en = 0; e_done = 0; e_err = 0;
    start_ok = st && (w >= 3) && (w <= MAXW) && (h >= 3) && (h <= 63);
    if (st && !start_ok) e_err = 1;
    if (start_ok) begin
      m_run = 1; m_w = w; m_h = h; m_r = 0; m_c = 0;
    end else if (vld && m_run) begin
      img[m_r][m_c] = px;
      if (m_r >= 2 && m_c >= 2) begin
        exp_q.push_back(window_at(m_r, m_c));
        e_en = 1;
      end
      if (m_r == m_h - 1 && m_c == m_w - 1) begin
        m_run  = 0;
        e_done = 1;
      end else if (m_c == m_w - 1) begin
        m_c = 0;
        m_r++;
      end else begin
        m_c++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_en !== e_en) begin
      n_bad++;
      $display("FAIL out_en t=%0t got=%b exp=%b", $time, bus.out_en, e_en);
    end
    if (e_en && exp_q.size() > 0) m_out = exp_q.pop_front();
    n_cmp++;
    if (bus.out !== m_out) begin
      n_bad++;
      $display("FAIL out t=%0t got=%h exp=%h", $time, bus.out, m_out);
    end
    if (bus.out_en === 1'b1) got_q.push_back(bus.out);
    n_cmp++;
    if (bus.done !== e_done) begin
      n_bad++;
      $display("FAIL done t=%0t got=%b exp=%b", $time, bus.done, e_done);
    end
    n_cmp++;
    if (bus.busy !== m_run) begin
      n_bad++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, bus.busy, m_run);
    end
    n_cmp++;
    if (bus.err !== e_err) begin
      n_bad++;
      $display("FAIL err t=%0t got=%b exp=%b", $time, bus.err, e_err);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.img_width  = '0;
    bus.img_height = '0;
    bus.in_pixel   = '0;
    bus.in_valid   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_en, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b%b%b%b out=%h exp=0", bus.out_en, bus.busy,
               bus.done, bus.err, bus.out);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic(input bit gaps);
    got_q.delete();
    cycle(1, 4, 4, 8'h00, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        cycle(0, 0, 0, 8'(16*r + c), 1);
        if (gaps) cycle(0, 0, 0, 8'hEE, 0);
      end
    idle(2);
    n_cmp++;
    if (got_q.size() != 4) begin
      n_bad++;
      $display("FAIL basic_count gaps=%0d got=%0d exp=4", gaps, got_q.size());
    end else if (!gaps) begin
      n_cmp++;
      if (got_q[0] !== 72'h22_21_20_12_11_10_02_01_00) begin
        n_bad++;
        $display("FAIL basic_first got=%h exp=222120121110020100", got_q[0]);
      end
      n_cmp++;
      if (got_q[3] !== 72'h33_32_31_23_22_21_13_12_11) begin
        n_bad++;
        $display("FAIL basic_last got=%h exp=333231232221131211", got_q[3]);
      end
      basic_q = got_q;
    end else begin
      for (int i = 0; i < 4 && i < basic_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== basic_q[i]) begin
          n_bad++;
          $display("FAIL gaps_window%0d got=%h exp=%h", i, got_q[i], basic_q[i]);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [WW-1:0] e;
    got_q.delete();
    cycle(1, MAXW, 3, 8'h00, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < MAXW; c++) cycle(0, 0, 0, 8'(c), 1);
    idle(2);
    n_cmp++;
    if (got_q.size() != MAXW - 2) begin
      n_bad++;
      $display("FAIL wide_count got=%0d exp=%0d", got_q.size(), MAXW - 2);
    end else begin
      for (int k = 0; k < MAXW - 2; k++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) e[CB*(3*i+j) +: CB] = 8'(k + j);
        n_cmp++;
        if (got_q[k] !== e) begin
          n_bad++;
          $display("FAIL wide_window%0d got=%h exp=%h", k, got_q[k], e);
        end
      end
    end
  endtask

  task automatic test_bad_dims();
    got_q.delete();
    cycle(1, 2, 4, 8'h00, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 8'($urandom_range(0, 255)), 1);
    cycle(1, 4, 2, 8'h00, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 8'($urandom_range(0, 255)), 1);
    cycle(1, MAXW + 1, 4, 8'h00, 0);
    idle(2);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL bad_dims_windows got=%0d exp=0", got_q.size());
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL bad_dims_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]    p [9];
    logic [WW-1:0] e;
    cycle(1, 4, 4, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'(i + 1), 1);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_en, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.out !== '0
        || dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL midframe_reset got=%b%b%b%b state=%0d out=%h exp=0", bus.out_en,
               bus.busy, bus.done, bus.err, dbg_state, bus.out);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(3);
    got_q.delete();
    cycle(1, 3, 3, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      p[i] = 8'($urandom_range(0, 255));
      cycle(0, 0, 0, p[i], 1);
    end
    idle(2);
    for (int k = 0; k < 9; k++) e[CB*k +: CB] = p[k];
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL after_reset_count got=%0d exp=1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== e) begin
        n_bad++;
        $display("FAIL after_reset_window got=%h exp=%h", got_q[0], e);
      end
    end
  endtask

  task automatic test_restart();
    got_q.delete();
    cycle(1, 4, 4, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'($urandom_range(0, 255)), 1);
    cycle(1, 4, 3, 8'hAA, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 8'($urandom_range(0, 255)), 1);
    idle(2);
    n_cmp++;
    if (got_q.size() != 2) begin
      n_bad++;
      $display("FAIL restart_count got=%0d exp=2", got_q.size());
    end
  endtask

  // Random dims and gaps; frames start back-to-back, so each new start
  // lands in the cycle the previous frame reports done.
  task automatic test_back_to_back();
    int w, h, n;
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(3, 9);
      h = $urandom_range(3, 6);
      got_q.delete();
      cycle(1, w, h, 8'h00, 0);
      n = 0;
      while (n < w * h) begin
        if ($urandom_range(0, 2) == 0) begin
          cycle(0, 0, 0, 8'($urandom_range(0, 255)), 0);
        end else begin
          cycle(0, 0, 0, 8'($urandom_range(0, 255)), 1);
          n++;
        end
      end
      n_cmp++;
      if (got_q.size() != (w - 2) * (h - 2)) begin
        n_bad++;
        $display("FAIL b2b_count w=%0d h=%0d got=%0d exp=%0d", w, h, got_q.size(),
                 (w - 2) * (h - 2));
      end
    end
    idle(2);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_wide();
    test_bad_dims();
    test_reset_midframe();
    test_restart();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
